// File: rtl/sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_window_ctrl
//
// Streams RGB444 camera pixels into two line buffers and builds a 3x3
// neighbourhood for an external combinational Sobel kernel. It tracks the
// frame position, zeroes the invalid top/left border of the window, registers
// the kernel result and applies the per-frame output mode (bypass, magnitude or
// binary edge) before the frame-buffer write.
//
// Ports
//   clk          pixel clock (only clock)
//   rst_n        asynchronous active-low reset
//   cfg_mode     00 bypass, 01 magnitude, 10 binary, 11 magnitude
//   cfg_thresh   binary-mode nibble threshold
//   pix_in       RGB444 pixel {R,G,B}
//   pix_valid    pixel present this cycle (no backpressure)
//   pix_sof      qualifies pix_valid, marks pixel (0,0)
//   win_*        window taps to the kernel; l/m/r = column x-2/x-1/x,
//                u/m/d = row y-2/y-1/y (centre not exported)
//   sobel_edge   per-channel 4-bit kernel result, combinational from win_*
//   edge_out     processed pixel, one cycle after each accepted pixel
//   edge_valid   edge_out valid
//   edge_sof     edge_out is the first pixel of a frame
//   frame_done   pulse with the output of pixel (H-1,V-1)
//   frame_err    pulse for a mid-frame sof or a pixel outside a frame
// -----------------------------------------------------------------------------
module sobel_window_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cfg_mode,
  input  logic [3:0]  cfg_thresh,
  input  logic [11:0] pix_in,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic [11:0] win_lu,
  output logic [11:0] win_lm,
  output logic [11:0] win_ld,
  output logic [11:0] win_mu,
  output logic [11:0] win_md,
  output logic [11:0] win_ru,
  output logic [11:0] win_rm,
  output logic [11:0] win_rd,
  input  logic [11:0] sobel_edge,
  output logic [11:0] edge_out,
  output logic        edge_valid,
  output logic        edge_sof,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int DATA_W = 12;
  localparam int XW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [XW-1:0] x, px;
  logic [YW-1:0] y, py;

  logic [1:0] mode_q, mode_eff;
  logic [3:0] thresh_q, thresh_eff;

  logic sof_in, accept, restart_err, drop_err, last_pix, wv;

  logic [DATA_W-1:0] lb0 [H_ACTIVE];
  logic [DATA_W-1:0] lb1 [H_ACTIVE];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [DATA_W-1:0] cur_u, cur_m;
  logic [DATA_W-1:0] c1_u, c1_m, c1_d;
  logic [DATA_W-1:0] c2_u, c2_m, c2_d;

  // ---------------------------------------------------------------------------
  // Output shaping helpers
  // ---------------------------------------------------------------------------
  function automatic logic nibble_hit(input logic [DATA_W-1:0] kern,
                                      input logic [3:0]        thr);
    return (kern[11:8] >= thr) || (kern[7:4] >= thr) || (kern[3:0] >= thr);
  endfunction

  function automatic logic [DATA_W-1:0] shape_output(input logic [1:0]        mode,
                                                     input logic [3:0]        thr,
                                                     input logic              win_ok,
                                                     input logic [DATA_W-1:0] pix,
                                                     input logic [DATA_W-1:0] kern);
    logic [DATA_W-1:0] r;
    r = '0;
    case (mode)
      2'b00:   r = pix;
      2'b10:   r = (win_ok && nibble_hit(kern, thr)) ? '1 : '0;
      default: r = win_ok ? kern : '0;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Acceptance and frame position of the incoming pixel
  // ---------------------------------------------------------------------------
  assign sof_in      = pix_valid & pix_sof;
  assign accept      = pix_valid & (pix_sof | (state == S_ACTIVE));
  assign restart_err = sof_in & (state == S_ACTIVE) & ((x != '0) | (y != '0));
  assign drop_err    = pix_valid & ~pix_sof & (state != S_ACTIVE);

  // A sof always lands at (0,0), even when it interrupts a frame.
  assign px = sof_in ? '0 : x;
  assign py = sof_in ? '0 : y;

  // A sof on the would-be last pixel restarts the frame instead of ending it.
  assign last_pix = accept & ~pix_sof & (px == X_LAST) & (py == Y_LAST);
  assign wv       = (px >= XW'(2)) && (py >= YW'(2));

  // The sof pixel already runs with the configuration it latches.
  assign mode_eff   = sof_in ? cfg_mode   : mode_q;
  assign thresh_eff = sof_in ? cfg_thresh : thresh_q;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (sof_in) state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (sof_in)        state_nxt = S_ACTIVE;
        else if (last_pix) state_nxt = S_DONE;
      end
      S_DONE:   if (sof_in) state_nxt = S_ACTIVE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Position counters and per-frame configuration shadow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      mode_q   <= 2'b01;
      thresh_q <= 4'h0;
    end else begin
      if (sof_in) begin
        mode_q   <= cfg_mode;
        thresh_q <= cfg_thresh;
      end
      if (accept) begin
        if (px == X_LAST) begin
          x <= '0;
          y <= (py == Y_LAST) ? '0 : py + YW'(1);
        end else begin
          x <= px + XW'(1);
          y <= py;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: read-before-write, LB0 = row y-1, LB1 = row y-2
  // ---------------------------------------------------------------------------
  assign lb0_rd = lb0[px];
  assign lb1_rd = lb1[px];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[px] <= lb0[px];
      lb0[px] <= pix_in;
    end
  end

  // Rows above the frame hold stale data from a previous frame; zero them.
  assign cur_u = (py >= YW'(2)) ? lb1_rd : '0;
  assign cur_m = (py >= YW'(1)) ? lb0_rd : '0;

  // ---------------------------------------------------------------------------
  // Column shift registers (columns x-1 and x-2)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      if (px == X_LAST) begin
        c1_u <= '0; c1_m <= '0; c1_d <= '0;
        c2_u <= '0; c2_m <= '0; c2_d <= '0;
      end else begin
        c2_u <= c1_u;  c2_m <= c1_m;  c2_d <= c1_d;
        c1_u <= cur_u; c1_m <= cur_m; c1_d <= pix_in;
      end
    end
  end

  // Left-column masking also covers a sof that restarts in mid-line, where
  // the shift registers still hold columns of the abandoned line.
  assign win_lu = (px <= XW'(1)) ? '0 : c2_u;
  assign win_lm = (px <= XW'(1)) ? '0 : c2_m;
  assign win_ld = (px <= XW'(1)) ? '0 : c2_d;
  assign win_mu = (px == '0)     ? '0 : c1_u;
  assign win_md = (px == '0)     ? '0 : c1_d;
  assign win_ru = cur_u;
  assign win_rm = cur_m;
  assign win_rd = pix_in;

  // ---------------------------------------------------------------------------
  // Output register stage (latency 1 from accept)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_out   <= '0;
      edge_valid <= 1'b0;
      edge_sof   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      edge_valid <= accept;
      edge_sof   <= sof_in;
      frame_done <= last_pix;
      frame_err  <= restart_err | drop_err;
      if (accept) edge_out <= shape_output(mode_eff, thresh_eff, wv, pix_in, sobel_edge);
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
module tb_sobel_window_ctrl;
  localparam int H = 8;
  localparam int V = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfg_mode;
  logic [3:0]  cfg_thresh;
  logic [11:0] pix_in;
  logic        pix_valid, pix_sof;
  logic [11:0] win_lu, win_lm, win_ld, win_mu, win_md, win_ru, win_rm, win_rd;
  logic [11:0] sobel_edge, edge_out;
  logic        edge_valid, edge_sof, frame_done, frame_err;

  sobel_window_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .win_lu(win_lu), .win_lm(win_lm), .win_ld(win_ld), .win_mu(win_mu),
    .win_md(win_md), .win_ru(win_ru), .win_rm(win_rm), .win_rd(win_rd),
    .sobel_edge(sobel_edge), .edge_out(edge_out), .edge_valid(edge_valid),
    .edge_sof(edge_sof), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Per-channel Sobel magnitude |gx|+|gy|, saturated to 4 bits.
  function automatic logic [11:0] kernel(input logic [11:0] lu, lm, ld, mu, md, ru, rm, rd);
    logic [11:0] r;
    int gx, gy, m;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      gx = (int'(ru[4*c +: 4]) + 2*int'(rm[4*c +: 4]) + int'(rd[4*c +: 4]))
         - (int'(lu[4*c +: 4]) + 2*int'(lm[4*c +: 4]) + int'(ld[4*c +: 4]));
      gy = (int'(ld[4*c +: 4]) + 2*int'(md[4*c +: 4]) + int'(rd[4*c +: 4]))
         - (int'(lu[4*c +: 4]) + 2*int'(mu[4*c +: 4]) + int'(ru[4*c +: 4]));
      m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (m > 15) m = 15;
      r[4*c +: 4] = 4'(m);
    end
    return r;
  endfunction

  always_comb sobel_edge = kernel(win_lu, win_lm, win_ld, win_mu, win_md, win_ru, win_rm, win_rd);

  // Test images: 0 flat 555, 1 step 000|FFF at x=4, 2 step 000|444 at x=4.
  function automatic logic [11:0] img(input int kind, input int x, input int y);
    logic [11:0] p;
    p = 12'h000;
    case (kind)
      0: p = 12'h555;
      1: p = (x < 4) ? 12'h000 : 12'hFFF;
      2: p = (x < 4) ? 12'h000 : 12'h444;
      default: p = 12'h000;
    endcase
    if (y < 0) p = 12'h000;
    return p;
  endfunction

  function automatic logic [11:0] exp_pix(input int kind, input logic [1:0] mode,
                                          input logic [3:0] thr, input int x, input int y);
    logic [11:0] e;
    if (mode == 2'b00) return img(kind, x, y);
    if (!(x >= 2 && y >= 2)) return 12'h000;
    e = kernel(img(kind, x-2, y-2), img(kind, x-2, y-1), img(kind, x-2, y),
               img(kind, x-1, y-2), img(kind, x-1, y),
               img(kind, x, y-2),   img(kind, x, y-1),   img(kind, x, y));
    if (mode == 2'b10)
      return (e[11:8] >= thr || e[7:4] >= thr || e[3:0] >= thr) ? 12'hFFF : 12'h000;
    return e;
  endfunction

  typedef struct {
    logic [11:0] out;
    logic        sof;
    logic        last;
    int          cyc;
  } exp_t;

  typedef struct {
    string name;
    int    act;
    int    req;
  } chk_t;

  exp_t sbq[$];
  chk_t chkq[$];
  int   tests = 0, fails = 0;
  int   cyc = 0;
  int   n_valid = 0, n_done = 0, n_err = 0, n_nz = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: the only process that performs comparisons.
  always @(posedge clk) begin
    exp_t e;
    chk_t c;
    #1;
    if (edge_valid) begin
      n_valid++;
      if (edge_out != 12'h000) n_nz++;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got edge_out=%h, required no output", edge_out);
      end else begin
        e = sbq.pop_front();
        if (edge_out !== e.out) begin
          fails++;
          $display("FAIL edge_out: got %h, required %h (cycle %0d)", edge_out, e.out, cyc);
        end
        tests++;
        if (cyc != e.cyc) begin
          fails++;
          $display("FAIL latency: output at cycle %0d, required cycle %0d", cyc, e.cyc);
        end
        tests++;
        if (edge_sof !== e.sof) begin
          fails++;
          $display("FAIL edge_sof: got %b, required %b", edge_sof, e.sof);
        end
        tests++;
        if (frame_done !== e.last) begin
          fails++;
          $display("FAIL frame_done: got %b, required %b", frame_done, e.last);
        end
      end
    end
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
    while (chkq.size() > 0) begin
      c = chkq.pop_front();
      tests++;
      if (c.act != c.req) begin
        fails++;
        $display("FAIL %s: got %0d, required %0d", c.name, c.act, c.req);
      end
    end
  end

  task automatic req(input string n, input int a, input int r);
    chkq.push_back('{n, a, r});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
    end
  endtask

  // Streams pixels 0..n-1 of an image, starting with a sof.
  task automatic send_frame(input int kind, input logic [1:0] mode, input logic [3:0] thr,
                            input bit gaps, input int n, input bit chg);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (gaps) idle($urandom_range(0, 1));
      @(negedge clk);
      if (i == 0) begin
        cfg_mode   = mode;
        cfg_thresh = thr;
      end
      if (chg && i == 20) begin
        cfg_mode   = 2'b00;
        cfg_thresh = 4'h0;
      end
      pix_in    = img(kind, i % H, i / H);
      pix_valid = 1'b1;
      pix_sof   = (i == 0);
      e.out  = exp_pix(kind, mode, thr, i % H, i / H);
      e.sof  = (i == 0);
      e.last = (i == H*V - 1);
      e.cyc  = cyc + 1;
      sbq.push_back(e);
    end
  endtask

  task automatic send_drop(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_in    = 12'hABC;
      pix_valid = 1'b1;
      pix_sof   = 1'b0;
    end
  endtask

  int v0, d0, e0, z0;

  task automatic snap();
    v0 = n_valid; d0 = n_done; e0 = n_err; z0 = n_nz;
  endtask

  task automatic frame_check(input string tag, input int valid, input int done,
                             input int err, input int nz);
    req({tag, "_valid"},   n_valid - v0, valid);
    req({tag, "_done"},    n_done  - d0, done);
    req({tag, "_err"},     n_err   - e0, err);
    req({tag, "_nonzero"}, n_nz    - z0, nz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cfg_mode = 2'b01; cfg_thresh = 4'h0;
    pix_in = '0; pix_valid = 1'b0; pix_sof = 1'b0;
    repeat (3) @(negedge clk);
    req("rst_edge_out",   int'(edge_out),   0);
    req("rst_edge_valid", int'(edge_valid), 0);
    req("rst_edge_sof",   int'(edge_sof),   0);
    req("rst_frame_done", int'(frame_done), 0);
    req("rst_frame_err",  int'(frame_err),  0);
    rst_n = 1'b1;

    // Flat 555, magnitude: all zero, one frame_done.
    snap(); send_frame(0, 2'b01, 4'h0, 0, H*V, 0); idle(3);
    frame_check("flat", 48, 1, 0, 0);

    // Pixels without sof in DONE are dropped with frame_err.
    snap(); send_drop(2); idle(3);
    frame_check("drop_done", 0, 0, 2, 0);

    // Step 000|FFF, magnitude: x=4,5 of rows 2..5 saturate to FFF.
    snap(); send_frame(1, 2'b01, 4'h0, 0, H*V, 0); idle(3);
    frame_check("step_mag", 48, 1, 0, 8);

    // Mode 11 behaves as magnitude.
    snap(); send_frame(1, 2'b11, 4'h0, 0, H*V, 0); idle(3);
    frame_check("step_m11", 48, 1, 0, 8);

    // Binary, thresh 8, step 000|444, mode changed mid-frame (ignored).
    snap(); send_frame(2, 2'b10, 4'h8, 0, H*V, 1); idle(3);
    frame_check("binary", 48, 1, 0, 8);

    // Binary with thresh 0: every window pixel (x>=2,y>=2) is FFF.
    snap(); send_frame(0, 2'b10, 4'h0, 0, H*V, 0); idle(3);
    frame_check("bin_t0", 48, 1, 0, 24);

    // Bypass: raw pixels including the border.
    snap(); send_frame(0, 2'b00, 4'h0, 0, H*V, 0); idle(3);
    frame_check("bypass", 48, 1, 0, 48);

    // Random gaps: same image result, latency still checked per pixel.
    snap(); send_frame(1, 2'b01, 4'h0, 1, H*V, 0); idle(3);
    frame_check("gaps", 48, 1, 0, 8);

    // sof at (3,2) restarts the frame with a frame_err pulse.
    snap();
    send_frame(1, 2'b01, 4'h0, 0, 2*H + 3, 0);
    send_frame(1, 2'b01, 4'h0, 0, H*V, 0); idle(3);
    frame_check("restart", 2*H + 3 + 48, 1, 1, 8);

    // Reset asserted while pixel (5,3) is presented.
    snap();
    send_frame(1, 2'b01, 4'h0, 0, 3*H + 5, 0);
    @(negedge clk);
    pix_in = img(1, 5, 3); pix_valid = 1'b1; pix_sof = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    req("rstmid_edge_valid", int'(edge_valid), 0);
    req("rstmid_edge_out",   int'(edge_out),   0);
    req("rstmid_frame_done", int'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pix_valid = 1'b0;
    idle(1);
    snap(); send_drop(3); idle(3);
    frame_check("post_rst_drop", 0, 0, 3, 0);
    snap(); send_frame(1, 2'b01, 4'h0, 0, H*V, 0); idle(3);
    frame_check("post_rst", 48, 1, 0, 8);

    req("sb_empty", sbq.size(), 0);
    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
